lfu_counter_bank: RTL and testbench
===================================

LFU_COUNTER_BANK -- requirements
Module: lfu_counter_bank

Interface
REQ-001 The block SHALL have parameter sizeCounter, default 4: width of each per-way use counter.
REQ-002 The block SHALL have parameter NUM_SETS, default 16: number of cache sets; power of two, at least 2.
REQ-003 The block SHALL have parameter setBits, default 4: equal to log2(NUM_SETS).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port access_valid, input, 1 bit: cache access presented this cycle.
REQ-007 The block SHALL have port access_ready, output, 1 bit: the block accepts an access this cycle.
REQ-008 The block SHALL have port access_set, input, setBits bits: set index of the access.
REQ-009 The block SHALL have port hit, input, 1 bit: 1 = hit, 0 = miss with fill.
REQ-010 The block SHALL have port way_sel, input, 4 bits: one-hot way; the hit way on a hit, the victim way (LFU cache_sel) on a miss.
REQ-011 The block SHALL have port decay_req, input, 1 bit: request a full aging sweep.
REQ-012 The block SHALL have port rd_set, input, setBits bits: set whose counters are presented on count0..count3.
REQ-013 The block SHALL have ports count0, count1, count2, count3, output, sizeCounter bits each: stored counters of ways 0-3 of rd_set.
REQ-014 The block SHALL have port busy, output, 1 bit: aging sweep in progress.
REQ-015 The block SHALL have port decay_done, output, 1 bit: single-cycle pulse when a sweep completes.
REQ-016 The block SHALL have port sel_err, output, 1 bit: single-cycle pulse when an accepted access had a non-one-hot way_sel.

Function
REQ-017 The block SHALL store NUM_SETS x 4 counters of sizeCounter bits and have two states, IDLE and DECAY.
REQ-018 In IDLE, access_ready SHALL be 1; in DECAY, access_ready SHALL be 0, and access_valid SHALL be ignored.
REQ-019 An access is accepted when access_valid && access_ready; its update SHALL be visible on count0..count3 in the next cycle (latency 1).
REQ-020 On an accepted hit, the counter of access_set/way_sel SHALL increment by 1, saturating at 2^sizeCounter-1.
REQ-021 An accepted hit to a counter already at 2^sizeCounter-1 SHALL leave it unchanged and set an internal sat_pending flag.
REQ-022 On an accepted miss, the counter of access_set/way_sel SHALL be written to 1, and the other three ways SHALL be unchanged.
REQ-023 If way_sel of an accepted access is 4'b0000 or multi-hot, no counter SHALL change, and sel_err SHALL pulse in the next cycle.
REQ-024 count0..count3 SHALL be combinational reads of the stored counters of rd_set, with no write-through bypass.
REQ-025 IDLE SHALL go to DECAY at the next edge when decay_req=1 or sat_pending=1; entry SHALL clear sat_pending and load sweep index 0.
REQ-026 If an access and a DECAY trigger occur in the same IDLE cycle, the access SHALL be applied and DECAY entered at the same edge.
REQ-027 Each DECAY cycle SHALL replace all 4 counters of set sweep_idx with counter>>1 and then increment sweep_idx.
REQ-028 A sweep SHALL take exactly NUM_SETS cycles.
REQ-029 After processing set NUM_SETS-1, the block SHALL return to IDLE, and decay_done SHALL be 1 in the first IDLE cycle.
REQ-030 busy SHALL be 1 exactly while in DECAY.
REQ-031 decay_req asserted during DECAY SHALL be ignored and SHALL NOT queue another sweep.

Reset
REQ-032 While rst=1 at an edge, the block SHALL clear all counters to 0, set the state to IDLE, and clear sweep_idx and sat_pending to 0.
REQ-033 After reset, busy, decay_done and sel_err SHALL be 0 and access_ready SHALL be 1.
REQ-034 rst SHALL take priority over accesses and sweeps; a reset mid-sweep SHALL abort the sweep without a decay_done pulse.

Verification
REQ-035 The bench SHALL check: reset, then 3 hits on set 2 way 4'b0100, then rd_set=2 -> count2=3 and count0=count1=count3=0.
REQ-036 The bench SHALL check: 16 hits on set 5 way 4'b0001 (sizeCounter=4) -> count0 stays 15, busy rises the cycle after the 16th hit, the sweep runs 16 cycles, and set 5 reads count0=7.
REQ-037 The bench SHALL check: counters of set 1 = {9,4,6,2} and a miss on set 1 with way_sel=4'b1000 -> next cycle {9,4,6,1}.
REQ-038 The bench SHALL check: decay_req with access_valid in the same IDLE cycle -> the access is applied; then access_ready=0 for 16 cycles, and a hit offered during DECAY is not counted until accepted.
REQ-039 The bench SHALL check: way_sel=4'b0110 on a hit -> no counter changes and sel_err pulses once.
REQ-040 The bench SHALL check: rst=1 at sweep cycle 7 -> next cycle busy=0, all counters 0, and no decay_done pulse.

Source files
------------

// File: rtl/lfu_counter_bank.sv
// Per-set, per-way LFU use counters for a 4-way cache. Counters saturate
// on hits and are periodically halved by a full-bank aging sweep.
module lfu_counter_bank #(
    parameter int sizeCounter = 4,
    parameter int NUM_SETS    = 16,
    parameter int setBits     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   access_valid,
    output logic                   access_ready,
    input  logic [setBits-1:0]     access_set,
    input  logic                   hit,
    input  logic [3:0]             way_sel,
    input  logic                   decay_req,
    input  logic [setBits-1:0]     rd_set,
    output logic [sizeCounter-1:0] count0,
    output logic [sizeCounter-1:0] count1,
    output logic [sizeCounter-1:0] count2,
    output logic [sizeCounter-1:0] count3,
    output logic                   busy,
    output logic                   decay_done,
    output logic                   sel_err
);

    localparam logic [sizeCounter-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, DECAY} state_t;

    state_t                 state, state_nxt;
    logic [sizeCounter-1:0] cnt [NUM_SETS][4];
    logic [setBits-1:0]     sweep_idx;
    logic                   sat_pending;
    logic                   decay_done_r;
    logic                   sel_err_r;
    logic                   accept;
    logic                   sel_ok;
    logic                   sweep_last;
    logic                   sat_hit;
    logic                   enter_decay;

    function automatic logic [sizeCounter-1:0] sat_inc(input logic [sizeCounter-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic onehot4(input logic [3:0] s);
        return (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
    endfunction

    assign accept     = access_valid && (state == IDLE);
    assign sel_ok     = onehot4(way_sel);
    assign sweep_last = (sweep_idx == setBits'(NUM_SETS - 1));

    // A hit on an already-saturated counter schedules an aging sweep.
    always_comb begin
        sat_hit = 1'b0;
        for (int w = 0; w < 4; w++) begin
            if (way_sel[w] && (cnt[access_set][w] == CNT_MAX))
                sat_hit = 1'b1;
        end
        sat_hit = sat_hit && accept && hit && sel_ok;
    end

    always_comb begin
        state_nxt   = state;
        enter_decay = 1'b0;
        case (state)
            IDLE: begin
                if (decay_req || sat_pending) begin
                    state_nxt   = DECAY;
                    enter_decay = 1'b1;
                end
            end
            DECAY: begin
                if (sweep_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Entering a sweep discards sat_pending: the sweep itself ages the
    // counter that saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_idx    <= '0;
            sat_pending  <= 1'b0;
            decay_done_r <= 1'b0;
            sel_err_r    <= 1'b0;
        end else begin
            decay_done_r <= (state == DECAY) && sweep_last;
            sel_err_r    <= accept && !sel_ok;
            if (enter_decay) begin
                sat_pending <= 1'b0;
                sweep_idx   <= '0;
            end else begin
                if (sat_hit)
                    sat_pending <= 1'b1;
                if (state == DECAY)
                    sweep_idx <= sweep_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++)
                for (int w = 0; w < 4; w++)
                    cnt[s][w] <= '0;
        end else if (state == DECAY) begin
            for (int w = 0; w < 4; w++)
                cnt[sweep_idx][w] <= cnt[sweep_idx][w] >> 1;
        end else if (accept && sel_ok) begin
            for (int w = 0; w < 4; w++) begin
                if (way_sel[w])
                    cnt[access_set][w] <= hit ? sat_inc(cnt[access_set][w])
                                              : sizeCounter'(1);
            end
        end
    end

    assign count0       = cnt[rd_set][0];
    assign count1       = cnt[rd_set][1];
    assign count2       = cnt[rd_set][2];
    assign count3       = cnt[rd_set][3];
    assign busy         = (state == DECAY);
    assign access_ready = (state == IDLE);
    assign decay_done   = decay_done_r;
    assign sel_err      = sel_err_r;

endmodule

// File: tb/tb_lfu_counter_bank.sv
// Bench for lfu_counter_bank: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_lfu_counter_bank;

    localparam int SC   = 4;
    localparam int NS   = 16;
    localparam int SB   = 4;
    localparam int MAXV = (1 << SC) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          access_valid;
    logic          access_ready;
    logic [SB-1:0] access_set;
    logic          hit;
    logic [3:0]    way_sel;
    logic          decay_req;
    logic [SB-1:0] rd_set;
    logic [SC-1:0] count0, count1, count2, count3;
    logic          busy, decay_done, sel_err;

    lfu_counter_bank #(.sizeCounter(SC), .NUM_SETS(NS), .setBits(SB)) dut (
        .clk(clk), .rst(rst),
        .access_valid(access_valid), .access_ready(access_ready),
        .access_set(access_set), .hit(hit), .way_sel(way_sel),
        .decay_req(decay_req), .rd_set(rd_set),
        .count0(count0), .count1(count1), .count2(count2), .count3(count3),
        .busy(busy), .decay_done(decay_done), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counters as plain ints, a sweep as "sets left to age".
    int mcnt [NS][4];
    bit m_busy, m_sat, m_done, m_selerr;
    int m_idx;
    int mw;
    bit m_sathit;

    always @(posedge clk) begin
        if (rst) begin
            foreach (mcnt[s, w]) mcnt[s][w] = 0;
            m_busy = 0; m_sat = 0; m_done = 0; m_selerr = 0; m_idx = 0;
        end else begin
            m_done   = 0;
            m_selerr = 0;
            if (m_busy) begin
                for (int w = 0; w < 4; w++) mcnt[m_idx][w] = mcnt[m_idx][w] / 2;
                m_idx++;
                if (m_idx == NS) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else begin
                m_sathit = 0;
                if (access_valid) begin
                    if ($countones(way_sel) != 1) begin
                        m_selerr = 1;
                    end else begin
                        mw = 0;
                        for (int i = 0; i < 4; i++) if (way_sel[i]) mw = i;
                        if (!hit) mcnt[access_set][mw] = 1;
                        else if (mcnt[access_set][mw] == MAXV) m_sathit = 1;
                        else mcnt[access_set][mw]++;
                    end
                end
                if (decay_req || m_sat) begin
                    m_busy = 1; m_idx = 0; m_sat = 0;
                end else if (m_sathit) begin
                    m_sat = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("busy", busy, m_busy);
            chk("access_ready", access_ready, !m_busy);
            chk("decay_done", decay_done, m_done);
            chk("sel_err", sel_err, m_selerr);
            chk("count0", count0, mcnt[rd_set][0]);
            chk("count1", count1, mcnt[rd_set][1]);
            chk("count2", count2, mcnt[rd_set][2]);
            chk("count3", count3, mcnt[rd_set][3]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    task automatic acc(input int s, input bit h, input logic [3:0] w);
        access_valid = 1'b1;
        access_set   = SB'(s);
        hit          = h;
        way_sel      = w;
        tick();
        access_valid = 1'b0;
    endtask

    int cnt;
    int r;

    initial begin
        rst = 1'b1; access_valid = 1'b0; access_set = '0; hit = 1'b0;
        way_sel = 4'd0; decay_req = 1'b0; rd_set = '0;
        repeat (2) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        look();
        chk("rst_busy", busy, 0);
        chk("rst_ready", access_ready, 1);
        chk("rst_done", decay_done, 0);
        chk("rst_selerr", sel_err, 0);
        chk("rst_count0", count0, 0);

        // Three hits on set 2, way 2
        rd_set = 2;
        repeat (3) acc(2, 1'b1, 4'b0100);
        look();
        chk("s2_count2", count2, 3);
        chk("s2_count0", count0, 0);
        chk("s2_count1", count1, 0);
        chk("s2_count3", count3, 0);

        // Multi-hot way_sel
        acc(2, 1'b1, 4'b0110);
        look();
        chk("selerr_pulse", sel_err, 1);
        chk("selerr_count1", count1, 0);
        chk("selerr_count2", count2, 3);
        tick(); look();
        chk("selerr_once", sel_err, 0);

        // Miss fill on set 1
        rd_set = 1;
        repeat (9) acc(1, 1'b1, 4'b0001);
        repeat (4) acc(1, 1'b1, 4'b0010);
        repeat (6) acc(1, 1'b1, 4'b0100);
        repeat (2) acc(1, 1'b1, 4'b1000);
        look();
        chk("s1_pre_c3", count3, 2);
        acc(1, 1'b0, 4'b1000);
        look();
        chk("miss_c0", count0, 9);
        chk("miss_c1", count1, 4);
        chk("miss_c2", count2, 6);
        chk("miss_c3", count3, 1);

        // Saturation-triggered sweep
        rd_set = 5;
        repeat (15) acc(5, 1'b1, 4'b0001);
        look();
        chk("sat_reach", count0, 15);
        acc(5, 1'b1, 4'b0001);
        look();
        chk("sat_hold", count0, 15);
        chk("sat_busy_pre", busy, 0);
        tick(); look();
        chk("sat_busy_rise", busy, 1);
        cnt = 1;
        for (int k = 0; k < 40; k++) begin
            tick(); look();
            if (busy) cnt++;
            else break;
        end
        chk("sweep_len", cnt, 16);
        chk("sweep_done", decay_done, 1);
        chk("sat_aged", count0, 7);

        // Access plus decay_req in the same cycle; hit held during DECAY
        rd_set = 7;
        access_valid = 1'b1; access_set = 7; hit = 1'b1; way_sel = 4'b0010;
        decay_req = 1'b1;
        tick();
        decay_req = 1'b0;
        look();
        chk("same_cyc_applied", count1, 1);
        chk("same_cyc_ready", access_ready, 0);
        cnt = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            decay_req = (k < 6);
            look();
            if (!access_ready) cnt++;
            else break;
        end
        decay_req = 1'b0;
        chk("ready_low_len", cnt, 16);
        chk("held_not_counted", count1, 0);
        tick();
        access_valid = 1'b0;
        look();
        chk("held_accepted", count1, 1);
        repeat (3) tick();
        look();
        chk("no_queued_sweep", busy, 0);

        // Reset in the middle of a sweep
        rd_set = 3;
        repeat (5) acc(3, 1'b1, 4'b1000);
        decay_req = 1'b1;
        tick();
        decay_req = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        look();
        chk("abort_busy", busy, 0);
        chk("abort_done", decay_done, 0);
        chk("abort_count3", count3, 0);
        for (int s = 0; s < NS; s++) begin
            rd_set = SB'(s);
            tick(); look();
            chk("abort_clear", int'(count0) + int'(count1) + int'(count2) + int'(count3), 0);
            chk("abort_no_done", decay_done, 0);
        end

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            access_valid = ($urandom_range(0, 3) != 0);
            access_set   = SB'($urandom_range(0, NS - 1));
            hit          = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r == 0) way_sel = 4'($urandom_range(0, 15));
            else        way_sel = 4'(1 << $urandom_range(0, 3));
            decay_req    = ($urandom_range(0, 49) == 0);
            rst          = ($urandom_range(0, 499) == 0);
            rd_set       = SB'($urandom_range(0, NS - 1));
            tick();
        end
        access_valid = 1'b0; decay_req = 1'b0; rst = 1'b0;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
